// File: rtl/fpa_int_converter_pkg.sv
// Shared types and constants for the FP16 to int16 converter.
// Field geometry, saturation limits, FSM states and input classes.
package fpa_pkg;

    localparam int          FRAC_W   = 10;
    localparam int          EXP_W    = 5;
    localparam logic [4:0]  EXP_BIAS = 5'd15;
    localparam logic [15:0] INT_MAX  = 16'h7FFF;
    localparam logic [15:0] INT_MIN  = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        C_OVF,
        C_UNF,
        C_NAN,
        C_INF,
        C_ZERO,
        C_FRAC,
        C_BIG,
        C_NORM
    } cls_t;

endpackage

// File: rtl/fpa_int_converter_if.sv
// Operand/result handshake bundle of the FP16 to int16 converter.
// master: producer/consumer side; slave: the converter itself.
interface fpa_int_converter_if;

    logic [15:0] fp_in_34;
    logic        ovf_in_34;
    logic        unf_in_34;
    logic        in_valid_34;
    logic        in_ready_34;
    logic [15:0] int_out_34;
    logic        sat_flag_34;
    logic        inexact_flag_34;
    logic        out_valid_34;
    logic        out_ready_34;

    modport master (
        output fp_in_34, ovf_in_34, unf_in_34, in_valid_34, out_ready_34,
        input  in_ready_34, int_out_34, sat_flag_34, inexact_flag_34,
        input  out_valid_34
    );

    modport slave (
        input  fp_in_34, ovf_in_34, unf_in_34, in_valid_34, out_ready_34,
        output in_ready_34, int_out_34, sat_flag_34, inexact_flag_34,
        output out_valid_34
    );

endinterface

// File: rtl/fpa_int_converter_classify.sv
// Combinational classifier: picks the conversion class of an FP16 operand.
// Ports: i_fp/i_ovf/i_unf in; class, sign, shift dir/count, preload out.
module fp16_classify
    import fpa_pkg::*;
(
    input  logic [15:0] i_fp,
    input  logic        i_ovf,
    input  logic        i_unf,
    output cls_t        o_cls,
    output logic        o_sign,
    output logic        o_shl,
    output logic [3:0]  o_n,
    output logic [15:0] o_mag,
    output logic [15:0] o_res,
    output logic        o_sat,
    output logic        o_inx
);

    logic [EXP_W-1:0]  w_e;
    logic [FRAC_W-1:0] w_f;
    logic [15:0]       w_lim;

    assign w_e    = i_fp[FRAC_W +: EXP_W];
    assign w_f    = i_fp[FRAC_W-1:0];
    assign o_sign = i_fp[15];
    assign w_lim  = o_sign ? INT_MIN : INT_MAX;

    always_comb begin
        o_cls = C_NORM;
        o_shl = 1'b0;
        o_n   = 4'd0;
        o_mag = {5'd0, 1'b1, w_f};
        o_res = 16'd0;
        o_sat = 1'b0;
        o_inx = 1'b0;
        if (i_ovf) begin
            o_cls = C_OVF;
            o_res = w_lim;
            o_sat = 1'b1;
        end else if (i_unf) begin
            o_cls = C_UNF;
            o_inx = |i_fp[14:0];
        end else if (w_e == 5'd31 && w_f != '0) begin
            o_cls = C_NAN;
            o_sat = 1'b1;
        end else if (w_e == 5'd31) begin
            o_cls = C_INF;
            o_res = w_lim;
            o_sat = 1'b1;
        end else if (w_e == 5'd0) begin
            o_cls = C_ZERO;
            o_inx = |w_f;
        end else if (w_e < EXP_BIAS) begin
            o_cls = C_FRAC;
            o_inx = 1'b1;
        end else if (w_e >= 5'd30) begin
            // -32768 is the one E=15 value that fits exactly
            o_cls = C_BIG;
            o_res = w_lim;
            o_sat = !(o_sign && w_f == '0);
        end else begin
            // e in 15..29; E >= 10 <=> e >= 25. Low-nibble math gives |E-10|.
            o_shl = (w_e >= 5'd25);
            o_n   = o_shl ? (w_e[3:0] - 4'd9) : (4'd9 - w_e[3:0]);
        end
    end

endmodule

// File: rtl/fpa_int_converter.sv
// FP16 to signed int16 converter, truncating, saturating, one shift/clk.
// Ports: clk_34, rst_34 (async low), bus (slave modport of the handshake).
module fpa_int_converter
    import fpa_pkg::*;
#(
    parameter int FP_W  = 16,
    parameter int INT_W = 16
) (
    input  logic                clk_34,
    input  logic                rst_34,
    fpa_int_converter_if.slave  bus
);

    logic [FP_W-1:0]  w_fp;
    cls_t             w_cls;
    logic             w_sign;
    logic             w_shl;
    logic [3:0]       w_n;
    logic [15:0]      w_mag;
    logic [15:0]      w_res;
    logic             w_sat;
    logic             w_inx;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [INT_W-1:0] r_mag;
    logic             r_shl;
    logic             r_sticky;
    logic             r_sign;
    logic             r_norm;
    logic [INT_W-1:0] r_res;
    logic             r_sat_sp;
    logic             r_inx_sp;
    logic [INT_W-1:0] r_int_out;
    logic             r_sat;
    logic             r_inx;
    logic             r_out_valid;

    assign w_fp = bus.fp_in_34;

    fp16_classify u_classify (
        .i_fp   (w_fp),
        .i_ovf  (bus.ovf_in_34),
        .i_unf  (bus.unf_in_34),
        .o_cls  (w_cls),
        .o_sign (w_sign),
        .o_shl  (w_shl),
        .o_n    (w_n),
        .o_mag  (w_mag),
        .o_res  (w_res),
        .o_sat  (w_sat),
        .o_inx  (w_inx)
    );

    // Ready drops as soon as reset is asserted, not at the next edge.
    assign bus.in_ready_34     = (r_state == IDLE) && rst_34;
    assign bus.int_out_34      = r_int_out;
    assign bus.sat_flag_34     = r_sat;
    assign bus.inexact_flag_34 = r_inx;
    assign bus.out_valid_34    = r_out_valid;

    always_ff @(posedge clk_34 or negedge rst_34) begin
        if (!rst_34) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mag       <= '0;
            r_shl       <= 1'b0;
            r_sticky    <= 1'b0;
            r_sign      <= 1'b0;
            r_norm      <= 1'b0;
            r_res       <= '0;
            r_sat_sp    <= 1'b0;
            r_inx_sp    <= 1'b0;
            r_int_out   <= '0;
            r_sat       <= 1'b0;
            r_inx       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid_34) begin
                        r_cnt    <= w_n;
                        r_mag    <= w_mag;
                        r_shl    <= w_shl;
                        r_sticky <= 1'b0;
                        r_sign   <= w_sign;
                        r_norm   <= (w_cls == C_NORM);
                        r_res    <= w_res;
                        r_sat_sp <= w_sat;
                        r_inx_sp <= w_inx;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_shl) begin
                            r_mag <= r_mag << 1;
                        end else begin
                            r_mag    <= r_mag >> 1;
                            r_sticky <= r_sticky | r_mag[0];
                        end
                    end else begin
                        if (r_norm) begin
                            r_int_out <= r_sign ? (~r_mag + 16'd1) : r_mag;
                            r_sat     <= 1'b0;
                            r_inx     <= r_sticky;
                        end else begin
                            r_int_out <= r_res;
                            r_sat     <= r_sat_sp;
                            r_inx     <= r_inx_sp;
                        end
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready_34) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
